// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and load clamp helper.
`default_nettype none

package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// bcd_digit: one decade cell with clear/load/step and carry-borrow out.
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       step_in,
  input  logic       up_down,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       clear,
  input  logic       hold,
  output bcd_digit_t digit,
  output logic       step_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;
  logic       at_limit;

  always_comb begin
    at_limit = up_down ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
    step_out = step_in & at_limit;
    digit_d  = digit_q;
    if (clear) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (step_in && !hold) begin
      // A stepping digit at its limit rolls over; the carry leaves via step_out.
      if (up_down) digit_d = at_limit ? BCD_MIN : digit_q + 4'd1;
      else         digit_d = at_limit ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) digit_q <= BCD_MIN;
    else        digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

`default_nettype wire

// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: N-digit up/down BCD counter with load, clear, wrap/saturate and tc.
// Optional leading-zero blank output enabled by macro BCD_BLANK_LZ_EN.
`default_nettype none

module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int WRAP       = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_down,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
`ifdef BCD_BLANK_LZ_EN
  output logic [NUM_DIGITS-1:0]   blank,
`endif
  output logic                    tc
);

  localparam logic SATURATE = (WRAP == 0);

  logic [NUM_DIGITS:0] step;
  logic                hold;

  // step[NUM_DIGITS] is high exactly when en=1 and every digit sits at its limit.
  assign step[0] = en;
  assign hold    = SATURATE & step[NUM_DIGITS];
  assign tc      = step[NUM_DIGITS] & ~clear & ~load;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clock      (clock),
      .reset      (reset),
      .step_in    (step[i]),
      .up_down    (up_down),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .clear      (clear),
      .hold       (hold),
      .digit      (count[4*i +: 4]),
      .step_out   (step[i+1])
    );
  end

`ifdef BCD_BLANK_LZ_EN
  logic upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (count[4*i +: 4] == BCD_MIN);
      blank[i]   = upper_zero;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_ndigit.sv
// tb_bcd_counter_ndigit: directed plus randomized checks against an integer-value reference model.
`default_nettype none

module tb_bcd_counter_ndigit;

  logic        clock;
  logic        reset;
  logic        en;
  logic        up_down;
  logic        clear;
  logic        load;
  logic [7:0]  load_val_w;
  logic [15:0] load_val_s;
  logic [7:0]  count_w;
  logic [15:0] count_s;
  logic        tc_w;
  logic        tc_s;
`ifdef BCD_BLANK_LZ_EN
  logic [1:0]  blank_w;
  logic [3:0]  blank_s;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int vw = 0;
  int vs = 0;

  bcd_counter_ndigit #(.NUM_DIGITS(2), .WRAP(1)) dut_w (
    .clock(clock), .reset(reset), .en(en), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val_w), .count(count_w),
`ifdef BCD_BLANK_LZ_EN
    .blank(blank_w),
`endif
    .tc(tc_w)
  );

  bcd_counter_ndigit #(.NUM_DIGITS(4), .WRAP(0)) dut_s (
    .clock(clock), .reset(reset), .en(en), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val_s), .count(count_s),
`ifdef BCD_BLANK_LZ_EN
    .blank(blank_s),
`endif
    .tc(tc_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decimal value -> BCD nibbles
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          p;
    r = '0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // BCD nibbles with >9 read as 9 -> decimal value
  function automatic int from_bcd_clamped(input logic [31:0] b, input int n);
    int v;
    int p;
    int d;
    v = 0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic int next_val(input int v, input int maxv, input bit wrap,
                                  input int ldv);
    if (clear)        return 0;
    if (load)         return ldv;
    if (!en)          return v;
    if (up_down) begin
      if (v == maxv)  return wrap ? 0 : maxv;
      return v + 1;
    end
    if (v == 0)       return wrap ? maxv : 0;
    return v - 1;
  endfunction

  function automatic logic exp_tc(input int v, input int maxv);
    return en & ~clear & ~load & (up_down ? (v == maxv) : (v == 0));
  endfunction

  function automatic logic [31:0] exp_blank(input int v, input int n);
    logic [31:0] r;
    int          p;
    r = '0;
    p = 10;
    for (int i = 1; i < n; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check_outputs();
    chk("count_w", {24'd0, count_w}, to_bcd(vw) & 32'h0000_00FF);
    chk("count_s", {16'd0, count_s}, to_bcd(vs) & 32'h0000_FFFF);
`ifdef BCD_BLANK_LZ_EN
    chk("blank_w", {30'd0, blank_w}, exp_blank(vw, 2));
    chk("blank_s", {28'd0, blank_s}, exp_blank(vs, 4));
`endif
  endtask

  // One clock with the currently driven inputs; tc checked before the edge, count after.
  task automatic cycle();
    #1;
    chk("tc_w", {31'd0, tc_w}, {31'd0, exp_tc(vw, 99)});
    chk("tc_s", {31'd0, tc_s}, {31'd0, exp_tc(vs, 9999)});
    @(posedge clock);
    vw = next_val(vw, 99,   1'b1, from_bcd_clamped({24'd0, load_val_w}, 2));
    vs = next_val(vs, 9999, 1'b0, from_bcd_clamped({16'd0, load_val_s}, 4));
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    en = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] val);
    idle_inputs();
    load       = 1'b1;
    load_val_s = val;
    load_val_w = val[7:0];
    cycle();
    load = 1'b0;
  endtask

  task automatic run(input logic dir, input int n);
    idle_inputs();
    en = 1'b1;
    up_down = dir;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    load_val_w = '0;
    load_val_s = '0;
    #12;
    chk("reset_w", {24'd0, count_w}, 32'h0);
    chk("reset_s", {16'd0, count_s}, 32'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Count to 47, then assert reset between edges.
    run(1'b1, 47);
    chk("at47", {24'd0, count_w}, 32'h47);
    #2;
    reset = 1'b0;
    #1;
    vw = 0; vs = 0;
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      check_outputs();
    end
    #3;
    reset = 1'b1;

    // Full up sweep with wrap, then saturate at top for the 4-digit copy.
    run(1'b1, 100);
    chk("wrap00", {24'd0, count_w}, 32'h00);
    do_load(16'h9999);
    run(1'b1, 2);
    chk("sat9999", {16'd0, count_s}, 32'h9999);

    // Down into zero: 2-digit wraps, 4-digit saturates.
    do_load(16'h0003);
    run(1'b0, 5);
    chk("sat0000", {16'd0, count_s}, 32'h0000);

    // Priority and clamp.
    idle_inputs();
    load = 1'b1; en = 1'b1;
    load_val_w = 8'hA7; load_val_s = 16'hF3A7;
    cycle();
    chk("clamp97", {24'd0, count_w}, 32'h97);
    clear = 1'b1; load = 1'b1;
    cycle();
    idle_inputs();
    do_load(16'h0042);
    for (int i = 0; i < 3; i++) cycle();

    // Direction toggling around 50.
    do_load(16'h0050);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_down = (i % 2 == 0);
      cycle();
    end

    // Leading-zero patterns.
    do_load(16'h0040);
    do_load(16'h0000);
    do_load(16'h1000);

    // Randomized operation.
    for (int i = 0; i < 600; i++) begin
      en         = ($urandom_range(0, 99) < 80);
      up_down    = ($urandom_range(0, 99) < 55);
      clear      = ($urandom_range(0, 99) < 3);
      load       = ($urandom_range(0, 99) < 6);
      load_val_w = 8'($urandom);
      load_val_s = 16'($urandom);
      if ($urandom_range(0, 99) < 5) begin
        load = 1'b1;
        load_val_s = ($urandom_range(0, 1) != 0) ? 16'h9998 : 16'h0001;
        load_val_w = load_val_s[7:0];
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
